// File: rtl/mips_cpu_harvard_run_monitor_if.sv
// CPU-facing signal bundle between the run monitor (master) and mips_cpu_harvard (slave).
interface mips_cpu_harvard_run_monitor_if;
   logic        cpu_active;
   logic [31:0] cpu_register_v0;
   logic        cpu_data_write;
   logic        cpu_reset;
   logic        cpu_clk_enable;

   modport master (
      input  cpu_active, cpu_register_v0, cpu_data_write,
      output cpu_reset, cpu_clk_enable
   );

   modport slave (
      output cpu_active, cpu_register_v0, cpu_data_write,
      input  cpu_reset, cpu_clk_enable
   );
endinterface

// File: rtl/mips_cpu_harvard_run_monitor.sv
// Run controller for mips_cpu_harvard: resets the CPU, times the run, enforces a
// timeout and checks register_v0 against an expected value on halt.
module mips_cpu_harvard_run_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 100,
   parameter int unsigned RESET_CYCLES   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [31:0]                    expected_v0,
   mips_cpu_harvard_run_monitor_if.master cpu,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic                           timeout,
   output logic                           no_start,
   output logic [31:0]                    result_v0,
   output logic [31:0]                    cycles,
   output logic [15:0]                    store_count
);

   localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_RST, S_CHECK, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [31:0]     expected_q, expected_d;
   logic            first_q, first_d;
   logic            pass_d, timeout_d, no_start_d;
   logic [31:0]     result_d, cycles_d, cycles_inc;
   logic [15:0]     store_d, store_inc;
   logic            cpu_reset_q, clk_en_q;

   assign cycles_inc = (cycles == '1) ? cycles : cycles + 32'd1;
   assign store_inc  = (store_count == '1) ? store_count : store_count + 16'd1;

   assign cpu.cpu_reset      = cpu_reset_q;
   assign cpu.cpu_clk_enable = clk_en_q;

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      expected_d = expected_q;
      first_d    = first_q;
      pass_d     = pass;
      timeout_d  = timeout;
      no_start_d = no_start;
      result_d   = result_v0;
      cycles_d   = cycles;
      store_d    = store_count;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               expected_d = expected_v0;
               rst_cnt_d  = RCW'(RESET_CYCLES);
               pass_d     = 1'b0;
               timeout_d  = 1'b0;
               no_start_d = 1'b0;
               result_d   = '0;
               cycles_d   = '0;
               store_d    = '0;
               state_d    = S_RST;
            end
         end
         S_RST: begin
            if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RCW'(1);
            if (rst_cnt_q <= RCW'(1)) state_d = S_CHECK;
         end
         S_CHECK: begin
            first_d = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            first_d  = 1'b0;
            cycles_d = cycles_inc;
            if (cpu.cpu_data_write) store_d = store_inc;
            // A halt seen on the timeout cycle still drains and is judged by v0.
            if (!cpu.cpu_active) begin
               if (first_q) begin
                  no_start_d = 1'b1;
                  state_d    = S_DONE;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (cycles_inc >= TIMEOUT_CYCLES) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DRAIN: begin
            result_d = cpu.cpu_register_v0;
            pass_d   = (cpu.cpu_register_v0 == expected_q);
            state_d  = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         expected_q  <= '0;
         first_q     <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         no_start    <= 1'b0;
         result_v0   <= '0;
         cycles      <= '0;
         store_count <= '0;
         cpu_reset_q <= 1'b1;
         clk_en_q    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         expected_q  <= expected_d;
         first_q     <= first_d;
         pass        <= pass_d;
         timeout     <= timeout_d;
         no_start    <= no_start_d;
         result_v0   <= result_d;
         cycles      <= cycles_d;
         store_count <= store_d;
         // Control outputs are registered from the next state so none is combinational.
         cpu_reset_q <= (state_d == S_IDLE) || (state_d == S_RST);
         clk_en_q    <= (state_d == S_RST) || (state_d == S_CHECK) ||
                        (state_d == S_RUN) || (state_d == S_DRAIN);
         busy        <= (state_d == S_RST) || (state_d == S_CHECK) ||
                        (state_d == S_RUN) || (state_d == S_DRAIN);
         done        <= (state_d == S_DONE);
      end
   end

endmodule

// File: tb/tb_mips_cpu_harvard_run_monitor.sv
// Directed bench for the run monitor with a stub CPU keyed off cpu_reset.
module tb_mips_cpu_harvard_run_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] expected_v0 = '0;
   logic        busy, done, pass, timeout, no_start;
   logic [31:0] result_v0, cycles;
   logic [15:0] store_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Stub CPU: k counts cycles since cpu_reset fell (k=0 is the CHECK cycle).
   int unsigned hold = 0;
   logic [31:0] stub_v0 = '0;
   bit          wr_en = 1'b0;
   logic [31:0] k = '0;

   mips_cpu_harvard_run_monitor_if cpu_if ();

   always #5 clk = ~clk;

   always @(posedge clk or posedge cpu_if.cpu_reset) begin
      if (cpu_if.cpu_reset) k <= '0;
      else if (k != 32'hFFFF_FFFF) k <= k + 32'd1;
   end

   assign cpu_if.cpu_active      = (k >= 32'd1) && (k <= hold);
   assign cpu_if.cpu_register_v0 = stub_v0;
   assign cpu_if.cpu_data_write  = wr_en && ((k == 32'd2) || (k == 32'd4) || (k == 32'd6));

   mips_cpu_harvard_run_monitor #(
      .TIMEOUT_CYCLES(100),
      .RESET_CYCLES  (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .expected_v0(expected_v0),
      .cpu        (cpu_if),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .timeout    (timeout),
      .no_start   (no_start),
      .result_v0  (result_v0),
      .cycles     (cycles),
      .store_count(store_count)
   );

   typedef struct {
      string       name;
      int unsigned hold;
      logic [31:0] v0;
      logic [31:0] exp_v0;
      bit          wr;
      logic        e_pass;
      logic        e_timeout;
      logic        e_no_start;
      logic [31:0] e_result;
      logic [31:0] e_cycles;
      logic [15:0] e_store;
      int unsigned e_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // poke>0 re-pulses start (with a bogus expected value) before edge 'poke' of the run.
   task automatic run_vec(input vec_t v, input int unsigned poke);
      int unsigned lat;
      hold    = v.hold;
      stub_v0 = v.v0;
      wr_en   = v.wr;
      @(negedge clk);
      start       = 1'b1;
      expected_v0 = v.exp_v0;
      @(posedge clk);
      #1;
      chk({v.name, " start.busy"}, 32'(busy), 32'd1);
      chk({v.name, " start.done"}, 32'(done), 32'd0);
      chk({v.name, " start.cpu_reset"}, 32'(cpu_if.cpu_reset), 32'd1);
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         if (i == poke) begin
            start       = 1'b1;
            expected_v0 = 32'h0000_DEAD;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (i == 1) begin
            chk({v.name, " check.cpu_reset"}, 32'(cpu_if.cpu_reset), 32'd0);
            chk({v.name, " check.clk_enable"}, 32'(cpu_if.cpu_clk_enable), 32'd1);
         end
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      chk({v.name, " latency"}, lat, v.e_lat);
      chk({v.name, " pass"}, 32'(pass), 32'(v.e_pass));
      chk({v.name, " timeout"}, 32'(timeout), 32'(v.e_timeout));
      chk({v.name, " no_start"}, 32'(no_start), 32'(v.e_no_start));
      chk({v.name, " result_v0"}, result_v0, v.e_result);
      chk({v.name, " cycles"}, cycles, v.e_cycles);
      chk({v.name, " store_count"}, 32'(store_count), 32'(v.e_store));
      chk({v.name, " done.busy"}, 32'(busy), 32'd0);
      chk({v.name, " done.clk_enable"}, 32'(cpu_if.cpu_clk_enable), 32'd0);
      chk({v.name, " done.cpu_reset"}, 32'(cpu_if.cpu_reset), 32'd0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " cpu_reset"}, 32'(cpu_if.cpu_reset), 32'd1);
      chk({tag, " clk_enable"}, 32'(cpu_if.cpu_clk_enable), 32'd0);
      chk({tag, " flags"}, {27'd0, busy, done, pass, timeout, no_start}, 32'd0);
      chk({tag, " result_v0"}, result_v0, 32'd0);
      chk({tag, " cycles"}, cycles, 32'd0);
      chk({tag, " store_count"}, 32'(store_count), 32'd0);
   endtask

   initial begin
      //           name        hold  v0            exp_v0        wr pass to ns result        cyc     st lat
      vecs[0] = '{"normal",    10,   32'h0000002A, 32'h0000002A, 1, 1, 0, 0, 32'h0000002A, 32'd11, 3, 14};
      vecs[1] = '{"wrong",     10,   32'h0000002B, 32'h0000002A, 0, 0, 0, 0, 32'h0000002B, 32'd11, 0, 14};
      vecs[2] = '{"timeout",   1000, 32'h0000002A, 32'h0000002A, 1, 0, 1, 0, 32'h00000000, 32'd100, 3, 102};
      vecs[3] = '{"no_start",  0,    32'h0000002A, 32'h0000002A, 1, 0, 0, 1, 32'h00000000, 32'd1,  0, 3};
      vecs[4] = '{"tie_pass",  99,   32'h00001234, 32'h00001234, 1, 1, 0, 0, 32'h00001234, 32'd100, 3, 103};
      vecs[5] = '{"tie_fail",  99,   32'h00001235, 32'h00001234, 0, 0, 0, 0, 32'h00001235, 32'd100, 0, 103};
      vecs[6] = '{"msb_diff",  3,    32'h80000000, 32'h00000000, 1, 0, 0, 0, 32'h80000000, 32'd4,  2, 7};
      vecs[7] = '{"short_all1", 1,   32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0, 0, 32'hFFFFFFFF, 32'd2,  1, 5};

      #12;
      chk_cleared("reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_cleared("idle");

      foreach (vecs[i]) run_vec(vecs[i], 0);

      // done and its result stay put while no start arrives
      run_vec(vecs[0], 0);
      repeat (3) @(posedge clk);
      #1;
      chk("sticky done", 32'(done), 32'd1);
      chk("sticky pass", 32'(pass), 32'd1);
      chk("sticky result", result_v0, 32'h0000002A);

      // start mid-run must not restart or relatch expected_v0
      run_vec(vecs[0], 5);

      // abort on RUN cycle 5, then a clean rerun
      hold    = 10;
      stub_v0 = 32'h0000002A;
      wr_en   = 1'b1;
      @(negedge clk);
      start       = 1'b1;
      expected_v0 = 32'h0000002A;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort pre busy", 32'(busy), 32'd1);
      chk("abort pre store_count", 32'(store_count), 32'd2);
      reset = 1'b0;
      #1;
      chk_cleared("abort");
      @(negedge clk);
      reset = 1'b1;
      run_vec(vecs[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
